// File: rtl/fht_io_sequencer_pkg.sv
// Shared definitions for the FHT frame sequencer.
//   DEF_*       default values for the sequencer parameters
//   state_e     sequencer FSM states (encodings are fixed: LOAD=0 .. UNLOAD=3)
//   bank_onehot one-hot write enable for a RAM bank number
package fht_io_sequencer_pkg;

  localparam int DEF_D_BIT  = 16;
  localparam int DEF_A_BIT  = 8;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/fht_io_sequencer_out_fifo.sv
// Show-ahead output FIFO for result bins.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_data    write side; a write while full is discarded
//   out_valid, out_data  head of the queue (out_data is 0 while empty)
//   out_ready            head is consumed when out_valid & out_ready
//   count                current occupancy, 0..DEPTH
module fht_io_sequencer_out_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push;
  logic             pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = in_valid && (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fht_io_sequencer.sv
// Frame sequencer in front of fht_top. Streams N = 4*2^A_BIT ADC samples into
// the four RAM banks, pulses start, waits for the done pulse, then streams the
// N result bins out in index order. Index n maps to bank n[A_BIT+1:A_BIT],
// address n[A_BIT-1:0] in both directions.
//   iCLK, iRESET                      clock, asynchronous active-low reset
//   iS_VALID, iS_DATA, oS_READY       sample input (valid/ready)
//   oFHT_DATA, oFHT_ADDR_WR, oFHT_WE  registered write port to fht_top
//   oFHT_START, iFHT_RDY              transform start pulse / done pulse
//   oFHT_ADDR_RD, iFHT_Q              shared read address / four bank outputs
//   oM_VALID, oM_DATA, oM_LAST, iM_READY  result bin output (valid/ready)
//   oBUSY                             high outside LOAD
//   oFRAME_CNT                        frames fully unloaded, wrapping
module fht_io_sequencer
  import fht_io_sequencer_pkg::*;
#(
  parameter int D_BIT  = DEF_D_BIT,
  parameter int A_BIT  = DEF_A_BIT,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iS_VALID,
  input  logic [D_BIT-2:0]        iS_DATA,
  output logic                    oS_READY,
  output logic [D_BIT-2:0]        oFHT_DATA,
  output logic [A_BIT-1:0]        oFHT_ADDR_WR,
  output logic [3:0]              oFHT_WE,
  output logic                    oFHT_START,
  input  logic                    iFHT_RDY,
  output logic [A_BIT-1:0]        oFHT_ADDR_RD,
  input  logic [4*D_BIT-1:0]      iFHT_Q,
  output logic                    oM_VALID,
  output logic signed [D_BIT-1:0] oM_DATA,
  output logic                    oM_LAST,
  input  logic                    iM_READY,
  output logic                    oBUSY,
  output logic [15:0]             oFRAME_CNT
);

  localparam int N     = 4 * (2 ** A_BIT);
  localparam int IN_W  = A_BIT + 2;
  localparam int RD_W  = A_BIT + 3;
  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e                  state_q, state_d;
  logic [IN_W-1:0]         in_cnt_q, in_cnt_d;
  logic [D_BIT-2:0]        wdata_q, wdata_d;
  logic [A_BIT-1:0]        waddr_q, waddr_d;
  logic [3:0]              we_q, we_d;
  logic                    start_q, start_d;
  logic [RD_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic [15:0]             frame_q, frame_d;
  logic [RD_LAT-1:0]       vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0]       last_pipe_q, last_pipe_d;
  logic [RD_LAT-1:0][1:0]  bank_pipe_q, bank_pipe_d;

  logic                    accept;
  logic                    issue;
  logic                    space;
  logic                    pop;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [CNT_W:0]          occ;
  logic signed [D_BIT-1:0] resp_data;
  logic                    fifo_valid;
  logic [D_BIT:0]          fifo_head;

  assign accept = iS_VALID && (state_q == ST_LOAD);
  assign pop    = fifo_valid && iM_READY;

  // Credit check: entries that will still occupy the FIFO plus reads already
  // issued must stay within DEPTH, so a returning read always finds room.
  // Counting this cycle's pop keeps a 1 bin/cycle stream going.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_pipe_q[i]);
    end
    occ   = {1'b0, fifo_cnt} + {1'b0, inflight} - (CNT_W + 1)'(pop);
    space = (occ < (CNT_W + 1)'(DEPTH));
  end

  // The first read (address 0) goes out in the same cycle the done pulse is
  // seen: the read address already rests at 0 in WAIT, which is what makes
  // the first bin appear RD_LAT+1 cycles after the done pulse.
  assign issue = space &&
                 (((state_q == ST_WAIT) && iFHT_RDY) ||
                  ((state_q == ST_UNLOAD) && (rd_cnt_q < RD_W'(N))));

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    we_d     = '0;
    start_d  = 1'b0;
    rd_cnt_d = rd_cnt_q;
    frame_d  = frame_q;
    if (issue) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wdata_d  = iS_DATA;
          waddr_d  = in_cnt_q[A_BIT-1:0];
          we_d     = bank_onehot(in_cnt_q[A_BIT+1:A_BIT]);
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_W'(N - 1)) begin
            state_d = ST_START;
          end
        end
      end
      // One cycle here lets the last write land before start is raised.
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (iFHT_RDY) begin
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (pop && fifo_head[D_BIT]) begin
          state_d  = ST_LOAD;
          frame_d  = frame_q + 1'b1;
          rd_cnt_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Read pipe: bank select and last flag travel with each read for RD_LAT cycles.
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    last_pipe_d    = last_pipe_q;
    bank_pipe_d    = bank_pipe_q;
    vld_pipe_d[0]  = issue;
    last_pipe_d[0] = issue && (rd_cnt_q == RD_W'(N - 1));
    bank_pipe_d[0] = rd_cnt_q[A_BIT+1:A_BIT];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
      bank_pipe_d[i] = bank_pipe_q[i-1];
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      we_q        <= '0;
      start_q     <= 1'b0;
      rd_cnt_q    <= '0;
      frame_q     <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      bank_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      start_q     <= start_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_q     <= frame_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      bank_pipe_q <= bank_pipe_d;
    end
  end

  // Read response stage: pick the bank that was addressed RD_LAT cycles ago.
  always_comb begin
    case (bank_pipe_q[RD_LAT-1])
      2'd1:    resp_data = iFHT_Q[2*D_BIT-1:D_BIT];
      2'd2:    resp_data = iFHT_Q[3*D_BIT-1:2*D_BIT];
      2'd3:    resp_data = iFHT_Q[4*D_BIT-1:3*D_BIT];
      default: resp_data = iFHT_Q[D_BIT-1:0];
    endcase
  end

  fht_io_sequencer_out_fifo #(
    .WIDTH (D_BIT + 1),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (iCLK),
    .rst_n     (iRESET),
    .in_valid  (vld_pipe_q[RD_LAT-1]),
    .in_data   ({last_pipe_q[RD_LAT-1], resp_data}),
    .out_valid (fifo_valid),
    .out_data  (fifo_head),
    .out_ready (iM_READY),
    .count     (fifo_cnt)
  );

  assign oS_READY     = (state_q == ST_LOAD);
  assign oBUSY        = (state_q != ST_LOAD);
  assign oFHT_DATA    = wdata_q;
  assign oFHT_ADDR_WR = waddr_q;
  assign oFHT_WE      = we_q;
  assign oFHT_START   = start_q;
  assign oFHT_ADDR_RD = (state_q == ST_UNLOAD) ? rd_cnt_q[A_BIT-1:0] : '0;
  assign oM_VALID     = fifo_valid;
  assign oM_DATA      = fifo_head[D_BIT-1:0];
  assign oM_LAST      = fifo_head[D_BIT];
  assign oFRAME_CNT   = frame_q;

endmodule
